sargantana_itag_ctrl: RTL

Tag-side controller for the instruction cache: the requester that drives the per-way tag memory array. Accepts lookup requests from fetch, reads every way's tag and valid bit, produces hit/miss with a one-hot hit way, selects a victim way on a miss, and writes the new tag when the refill arrives. It also sequences whole-cache invalidation through the array's flush input.

---
 rtl/sargantana_itag_ctrl_if.sv | 52 +++++
 rtl/sargantana_itag_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sargantana_itag_ctrl_if.sv
//------------------------------------------------------------------------------
// sargantana_itag_ctrl_if : fetch, refill, flush and tag-array signal bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sargantana_itag_ctrl_if #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_WIDHT      = 20,
  parameter int TAG_ADDR_WIDHT = 6
);
  logic                                     lookup_valid_i;
  logic                                     lookup_ready_o;
  logic [TAG_ADDR_WIDHT-1:0]                lookup_idx_i;
  logic [TAG_WIDHT-1:0]                     lookup_tag_i;
  logic                                     res_valid_o;
  logic                                     hit_o;
  logic                                     miss_o;
  logic [ICACHE_N_WAY-1:0]                  hit_way_o;
  logic [ICACHE_N_WAY-1:0]                  victim_way_o;
  logic                                     refill_valid_i;
  logic                                     refill_done_o;
  logic                                     flush_req_i;
  logic                                     flush_done_o;
  logic [ICACHE_N_WAY-1:0]                  tag_req_o;
  logic                                     tag_we_o;
  logic                                     tag_vbit_o;
  logic                                     tag_flush_o;
  logic [TAG_WIDHT-1:0]                     tag_data_o;
  logic [TAG_ADDR_WIDHT-1:0]                tag_addr_o;
  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0]   tag_way_i;
  logic [ICACHE_N_WAY-1:0]                  tag_vbit_i;

  // master is the controller; slave is fetch/refill/array side
  modport master (
    input  lookup_valid_i, lookup_idx_i, lookup_tag_i, refill_valid_i,
           flush_req_i, tag_way_i, tag_vbit_i,
    output lookup_ready_o, res_valid_o, hit_o, miss_o, hit_way_o, victim_way_o,
           refill_done_o, flush_done_o, tag_req_o, tag_we_o, tag_vbit_o,
           tag_flush_o, tag_data_o, tag_addr_o
  );

  modport slave (
    output lookup_valid_i, lookup_idx_i, lookup_tag_i, refill_valid_i,
           flush_req_i, tag_way_i, tag_vbit_i,
    input  lookup_ready_o, res_valid_o, hit_o, miss_o, hit_way_o, victim_way_o,
           refill_done_o, flush_done_o, tag_req_o, tag_we_o, tag_vbit_o,
           tag_flush_o, tag_data_o, tag_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/sargantana_itag_ctrl.sv
//------------------------------------------------------------------------------
// sargantana_itag_ctrl : I-cache tag-side controller (lookup, victim, refill,
// flush). Define SARGANTANA_ITAG_RANDOM_REPL_EN for LFSR replacement.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sargantana_itag_ctrl #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_WIDHT      = 20,
  parameter int TAG_ADDR_WIDHT = 6
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  sargantana_itag_ctrl_if.master bus
);

  localparam int c_PTR_W = $clog2(ICACHE_N_WAY);
  localparam logic [ICACHE_N_WAY-1:0] c_ONE = {{(ICACHE_N_WAY-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_MISS    = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [TAG_ADDR_WIDHT-1:0] r_idx;
  logic [TAG_WIDHT-1:0]      r_tag;
  logic [ICACHE_N_WAY-1:0]   r_victim;

  logic [ICACHE_N_WAY-1:0]   w_match;
  logic [ICACHE_N_WAY-1:0]   w_invalid_sel;
  logic [ICACHE_N_WAY-1:0]   w_repl_sel;
  logic [ICACHE_N_WAY-1:0]   w_victim;
  logic                      w_any_invalid;
  logic                      w_hit;
  logic                      w_accept;
  logic                      w_miss_now;

  assign w_accept   = (r_state == S_IDLE) & ~bus.flush_req_i & bus.lookup_valid_i;
  assign w_hit      = |w_match;
  assign w_miss_now = (r_state == S_COMPARE) & ~w_hit;

  always_comb begin
    w_match = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      w_match[w] = bus.tag_vbit_i[w] & (bus.tag_way_i[w] == r_tag);
    end
  end

  // Lowest-index invalid way wins over the replacement policy
  always_comb begin
    w_invalid_sel = '0;
    w_any_invalid = 1'b0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      if (!bus.tag_vbit_i[w] && !w_any_invalid) begin
        w_invalid_sel[w] = 1'b1;
        w_any_invalid    = 1'b1;
      end
    end
  end

`ifdef SARGANTANA_ITAG_RANDOM_REPL_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, free-running
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_repl_sel = c_ONE << r_lfsr[c_PTR_W-1:0];
`else
  logic [c_PTR_W-1:0] r_rr_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_miss_now && !w_any_invalid) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end

  assign w_repl_sel = c_ONE << r_rr_ptr;
`endif

  assign w_victim = w_any_invalid ? w_invalid_sel : w_repl_sel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_tag    <= '0;
      r_victim <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx <= bus.lookup_idx_i;
        r_tag <= bus.lookup_tag_i;
      end
      if (w_miss_now) begin
        r_victim <= w_victim;
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus.lookup_ready_o = (r_state == S_IDLE) & ~bus.flush_req_i;
    bus.res_valid_o    = 1'b0;
    bus.hit_o          = 1'b0;
    bus.miss_o         = 1'b0;
    bus.hit_way_o      = '0;
    bus.refill_done_o  = 1'b0;
    bus.flush_done_o   = 1'b0;
    bus.tag_req_o      = '0;
    bus.tag_we_o       = 1'b0;
    bus.tag_vbit_o     = 1'b0;
    bus.tag_flush_o    = 1'b0;
    bus.tag_data_o     = '0;
    bus.tag_addr_o     = '0;
    // The victim is visible in the miss cycle itself, then held from the register
    bus.victim_way_o   = w_miss_now ? w_victim : r_victim;

    case (r_state)
      S_IDLE: begin
        if (bus.flush_req_i) begin
          w_state_nxt = S_FLUSH;
        end else if (bus.lookup_valid_i) begin
          bus.tag_req_o  = '1;
          bus.tag_addr_o = bus.lookup_idx_i;
          w_state_nxt    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        bus.res_valid_o = 1'b1;
        bus.hit_o       = w_hit;
        bus.miss_o      = ~w_hit;
        bus.hit_way_o   = w_match;
        w_state_nxt     = w_hit ? S_IDLE : S_MISS;
      end
      S_MISS: begin
        if (bus.refill_valid_i) begin
          bus.tag_req_o     = r_victim;
          bus.tag_we_o      = 1'b1;
          bus.tag_vbit_o    = 1'b1;
          bus.tag_data_o    = r_tag;
          bus.tag_addr_o    = r_idx;
          bus.refill_done_o = 1'b1;
          w_state_nxt       = S_IDLE;
        end
      end
      S_FLUSH: begin
        bus.tag_flush_o  = 1'b1;
        bus.tag_req_o    = '1;
        bus.flush_done_o = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
